// File: rtl/uproc_core_p.sv
// Two-cycle accumulator microprocessor: FETCH loads IR and advances PC, EXEC runs the
// instruction. A small register file sits beside the accumulator; HLT parks the core.
module uproc_core_p #(
   parameter int DATA_W   = 8,
   parameter int NREGS    = 16,
   parameter int PM_DEPTH = 32,
   localparam int PC_W    = $clog2(PM_DEPTH),
   localparam int INS_W   = 4 + DATA_W
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              run,
   output logic [PC_W-1:0]   pm_addr,
   input  logic [INS_W-1:0]  pm_data,
   output logic [DATA_W-1:0] acc_out,
   output logic              carry,
   output logic              zero,
   output logic              halted
);

   localparam int RW = $clog2(NREGS);
   localparam int SW = DATA_W + 1;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_AND = 4'h7;
   localparam logic [3:0] OP_OR  = 4'h8;
   localparam logic [3:0] OP_XOR = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JC  = 4'hB;
   localparam logic [3:0] OP_JZ  = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hD;

   logic [1:0]        state_reg, state_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [INS_W-1:0]  ir_reg, ir_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic              carry_reg, carry_next;
   logic              zero_reg, zero_next;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] operand;
   logic [RW-1:0]     r_idx;
   logic [PC_W-1:0]   jmp_target;
   logic [DATA_W-1:0] r_val;
   logic [SW-1:0]     sum;
   logic              a_write;
   logic              reg_we;

   assign opcode     = ir_reg[INS_W-1:DATA_W];
   assign operand    = ir_reg[DATA_W-1:0];
   // Size casts give "operand mod 2^n" whether the index is narrower or wider than the data.
   assign r_idx      = RW'(operand);
   assign jmp_target = PC_W'(operand);

   logic [DATA_W-1:0] reg_rd [NREGS];

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
         logic [DATA_W-1:0] r_reg;
         always_ff @(posedge clk or negedge nReset) begin
            if (!nReset)
               r_reg <= '0;
            else if (reg_we && (r_idx == RW'(gi)))
               r_reg <= acc_reg;
         end
         assign reg_rd[gi] = r_reg;
      end
   endgenerate

   assign r_val = reg_rd[r_idx];

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      acc_next   = acc_reg;
      carry_next = carry_reg;
      zero_next  = zero_reg;
      sum        = '0;
      a_write    = 1'b0;
      reg_we     = 1'b0;
      if (run) begin
         case (state_reg)
            ST_FETCH: begin
               ir_next    = pm_data;
               pc_next    = pc_reg + PC_W'(1);
               state_next = ST_EXEC;
            end
            ST_EXEC: begin
               state_next = ST_FETCH;
               case (opcode)
                  OP_LDI: begin acc_next = operand; a_write = 1'b1; end
                  OP_LD:  begin acc_next = r_val;   a_write = 1'b1; end
                  OP_ST:  reg_we = 1'b1;
                  OP_ADD: begin
                     sum = {1'b0, acc_reg} + {1'b0, r_val};
                     {carry_next, acc_next} = sum;
                     a_write = 1'b1;
                  end
                  OP_ADC: begin
                     sum = {1'b0, acc_reg} + {1'b0, r_val} + SW'(carry_reg);
                     {carry_next, acc_next} = sum;
                     a_write = 1'b1;
                  end
                  // Top bit of the widened difference is the borrow.
                  OP_SUB: begin
                     sum = {1'b0, acc_reg} - {1'b0, r_val};
                     {carry_next, acc_next} = sum;
                     a_write = 1'b1;
                  end
                  OP_AND: begin acc_next = acc_reg & r_val; a_write = 1'b1; end
                  OP_OR:  begin acc_next = acc_reg | r_val; a_write = 1'b1; end
                  OP_XOR: begin acc_next = acc_reg ^ r_val; a_write = 1'b1; end
                  OP_JMP: pc_next = jmp_target;
                  OP_JC:  if (carry_reg) pc_next = jmp_target;
                  OP_JZ:  if (zero_reg)  pc_next = jmp_target;
                  OP_HLT: state_next = ST_HALT;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
      if (a_write)
         zero_next = (acc_next == '0);
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_reg <= ST_FETCH;
         pc_reg    <= '0;
         ir_reg    <= '0;
         acc_reg   <= '0;
         carry_reg <= 1'b0;
         zero_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         acc_reg   <= acc_next;
         carry_reg <= carry_next;
         zero_reg  <= zero_next;
      end
   end

   assign pm_addr = pc_reg;
   assign acc_out = acc_reg;
   assign carry   = carry_reg;
   assign zero    = zero_reg;
   assign halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_uproc_core_p.sv
// Bench for uproc_core_p: instruction-level reference interpreter for the default core,
// plus directed programs with hand-computed results on three parameterisations.
module tb_uproc_core_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   // default core: DATA_W=8, NREGS=16, PM_DEPTH=32
   logic        nreset_a = 1'b0, run_a = 1'b0;
   logic [4:0]  pm_addr_a;
   logic [11:0] pm_data_a;
   logic [7:0]  acc_a;
   logic        carry_a, zero_a, halted_a;
   logic [11:0] prog_a [32];
   assign pm_data_a = prog_a[pm_addr_a];

   uproc_core_p u_dut (
      .clk(clk), .nReset(nreset_a), .run(run_a), .pm_addr(pm_addr_a), .pm_data(pm_data_a),
      .acc_out(acc_a), .carry(carry_a), .zero(zero_a), .halted(halted_a)
   );

   // wide core: DATA_W=16, NREGS=4
   logic        nreset_w = 1'b0, run_w = 1'b0;
   logic [4:0]  pm_addr_w;
   logic [19:0] pm_data_w;
   logic [15:0] acc_w;
   logic        carry_w, zero_w, halted_w;
   logic [19:0] prog_w [32];
   assign pm_data_w = prog_w[pm_addr_w];

   uproc_core_p #(.DATA_W(16), .NREGS(4), .PM_DEPTH(32)) u_dut_w (
      .clk(clk), .nReset(nreset_w), .run(run_w), .pm_addr(pm_addr_w), .pm_data(pm_data_w),
      .acc_out(acc_w), .carry(carry_w), .zero(zero_w), .halted(halted_w)
   );

   // tiny program memory core: PM_DEPTH=4
   logic        nreset_p = 1'b0, run_p = 1'b0;
   logic [1:0]  pm_addr_p;
   logic [11:0] pm_data_p;
   logic [7:0]  acc_p;
   logic        carry_p, zero_p, halted_p;
   logic [11:0] prog_p [4];
   logic [1:0]  exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   assign pm_data_p = prog_p[pm_addr_p];

   uproc_core_p #(.DATA_W(8), .NREGS(16), .PM_DEPTH(4)) u_dut_p (
      .clk(clk), .nReset(nreset_p), .run(run_p), .pm_addr(pm_addr_p), .pm_data(pm_data_p),
      .acc_out(acc_p), .carry(carry_p), .zero(zero_p), .halted(halted_p)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference interpreter: every second enabled cycle completes one instruction.
   int m_pc = 0, m_a = 0, m_c = 0, m_z = 0, m_exec = 0, m_halted = 0;
   int m_r [16];
   logic [11:0] m_ir = '0;

   task automatic model_reset();
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_exec = 0; m_halted = 0; m_ir = '0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
   endtask

   task automatic model_tick();
      int op, opnd, r, t;
      if (m_halted != 0) return;
      if (m_exec == 0) begin
         m_ir = prog_a[m_pc];
         m_pc = (m_pc + 1) % 32;
         m_exec = 1;
         return;
      end
      m_exec = 0;
      op = int'(m_ir[11:8]);
      opnd = int'(m_ir[7:0]);
      r = opnd % 16;
      t = 0;
      case (op)
         1: m_a = opnd;
         2: m_a = m_r[r];
         3: m_r[r] = m_a;
         4: begin t = m_a + m_r[r]; m_c = (t > 255) ? 1 : 0; m_a = t % 256; end
         5: begin t = m_a + m_r[r] + m_c; m_c = (t > 255) ? 1 : 0; m_a = t % 256; end
         6: begin m_c = (m_r[r] > m_a) ? 1 : 0; m_a = (m_a - m_r[r] + 256) % 256; end
         7: m_a = m_a & m_r[r];
         8: m_a = m_a | m_r[r];
         9: m_a = m_a ^ m_r[r];
         10: m_pc = opnd % 32;
         11: if (m_c != 0) m_pc = opnd % 32;
         12: if (m_z != 0) m_pc = opnd % 32;
         13: m_halted = 1;
         default: ;
      endcase
      if (op >= 1 && op <= 9 && op != 3) m_z = (m_a == 0) ? 1 : 0;
   endtask

   always @(posedge clk or negedge nreset_a) begin
      if (!nreset_a) model_reset();
      else if (run_a) model_tick();
   end

   always @(posedge clk) begin
      #3;
      if (chk_en) begin
         check("model_pm_addr", 32'(pm_addr_a), m_pc);
         check("model_acc", 32'(acc_a), m_a);
         check("model_carry", 32'(carry_a), m_c);
         check("model_zero", 32'(zero_a), m_z);
         check("model_halted", 32'(halted_a), m_halted);
      end
   end

   task automatic hold_reset_a();
      @(negedge clk);
      nreset_a = 1'b0;
      run_a = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) prog_a[i] = 12'hD00;
   endtask

   task automatic release_a();
      @(negedge clk);
      nreset_a = 1'b1;
      run_a = 1'b1;
   endtask

   task automatic wait_halt_a(input int limit, output int cycles);
      cycles = 0;
      while (!halted_a && cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
      end
      check("halt_timeout", 32'(halted_a), 32'd1);
   endtask

   task automatic report_a(input string name);
      $display("prog %s: pm_addr=%0d acc=%h carry=%b zero=%b halted=%b",
               name, pm_addr_a, acc_a, carry_a, zero_a, halted_a);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 32; i++) begin prog_a[i] = 12'hD00; prog_w[i] = 20'hD0000; end
      for (int i = 0; i < 4; i++) prog_p[i] = 12'h000;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;

      // LDI 05; ST 3; LDI 0A; ADD 3; HLT -> halted on cycle 10
      prog_a[0] = 12'h105; prog_a[1] = 12'h303; prog_a[2] = 12'h10A;
      prog_a[3] = 12'h403; prog_a[4] = 12'hD00;
      release_a();
      repeat (9) @(posedge clk);
      #1 check("t1_halted_c9", 32'(halted_a), 32'd0);
      @(posedge clk);
      #1;
      check("t1_halted_c10", 32'(halted_a), 32'd1);
      check("t1_acc", 32'(acc_a), 32'h0F);
      check("t1_carry", 32'(carry_a), 32'd0);
      check("t1_zero", 32'(zero_a), 32'd0);
      report_a("add");
      // halt holds even with run toggled
      @(negedge clk); run_a = 1'b0;
      @(negedge clk); run_a = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_halt_hold", 32'(halted_a), 32'd1);

      hold_reset_a();
      check("rst_acc", 32'(acc_a), 32'd0);
      check("rst_pm_addr", 32'(pm_addr_a), 32'd0);
      check("rst_halted", 32'(halted_a), 32'd0);

      // LDI FF; ST 0; LDI 01; ADD 0; JC 7
      prog_a[0] = 12'h1FF; prog_a[1] = 12'h300; prog_a[2] = 12'h101;
      prog_a[3] = 12'h400; prog_a[4] = 12'hB07;
      release_a();
      repeat (10) @(posedge clk);
      #1;
      check("t2_pm_addr", 32'(pm_addr_a), 32'd7);
      check("t2_acc", 32'(acc_a), 32'h00);
      check("t2_carry", 32'(carry_a), 32'd1);
      check("t2_zero", 32'(zero_a), 32'd1);
      report_a("jc");
      wait_halt_a(20, cyc);

      // LDI 03; ST 1; LDI 02; SUB 1; ADC 1
      hold_reset_a();
      prog_a[0] = 12'h103; prog_a[1] = 12'h301; prog_a[2] = 12'h102;
      prog_a[3] = 12'h601; prog_a[4] = 12'h501;
      release_a();
      repeat (8) @(posedge clk);
      #1;
      check("t3_sub_acc", 32'(acc_a), 32'hFF);
      check("t3_sub_carry", 32'(carry_a), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("t3_adc_acc", 32'(acc_a), 32'h03);
      check("t3_adc_carry", 32'(carry_a), 32'd1);
      report_a("sub_adc");
      wait_halt_a(20, cyc);

      // first program again with 5-cycle stalls in FETCH and in EXEC -> halted on cycle 20
      hold_reset_a();
      prog_a[0] = 12'h105; prog_a[1] = 12'h303; prog_a[2] = 12'h10A;
      prog_a[3] = 12'h403; prog_a[4] = 12'hD00;
      @(negedge clk);
      nreset_a = 1'b1; run_a = 1'b0;
      repeat (5) @(negedge clk);
      run_a = 1'b1;
      repeat (3) @(negedge clk);
      run_a = 1'b0;
      repeat (5) @(negedge clk);
      run_a = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("t4_halted_c19", 32'(halted_a), 32'd0);
      @(posedge clk);
      #1;
      check("t4_halted_c20", 32'(halted_a), 32'd1);
      check("t4_acc", 32'(acc_a), 32'h0F);
      check("t4_carry", 32'(carry_a), 32'd0);
      check("t4_zero", 32'(zero_a), 32'd0);
      report_a("stall");

      // logic ops, register aliasing, taken/untaken jumps, E-opcode NOP, JMP target wrap
      hold_reset_a();
      prog_a[0]  = 12'h200; prog_a[1]  = 12'h10F; prog_a[2]  = 12'h312;
      prog_a[3]  = 12'h13C; prog_a[4]  = 12'h702; prog_a[5]  = 12'h802;
      prog_a[6]  = 12'h902; prog_a[7]  = 12'hC0A; prog_a[10] = 12'hB00;
      prog_a[11] = 12'h202; prog_a[12] = 12'hC00; prog_a[13] = 12'h000;
      prog_a[14] = 12'hE00; prog_a[15] = 12'hA31;
      release_a();
      wait_halt_a(100, cyc);
      check("t5_cycles", 32'(cyc), 32'd30);
      check("t5_pm_addr", 32'(pm_addr_a), 32'd18);
      check("t5_acc", 32'(acc_a), 32'h0F);
      check("t5_zero", 32'(zero_a), 32'd0);
      report_a("logic");
      chk_en = 1'b0;

      // DATA_W=16, NREGS=4: LDI 8000; ST 5 (R1); LD 1; ADD 1; HLT
      prog_w[0] = 20'h18000; prog_w[1] = 20'h30005; prog_w[2] = 20'h20001;
      prog_w[3] = 20'h40001; prog_w[4] = 20'hD0000;
      @(negedge clk);
      nreset_w = 1'b1; run_w = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("w_ld_alias", 32'(acc_w), 32'h8000);
      repeat (2) @(posedge clk);
      #1;
      check("w_acc", 32'(acc_w), 32'h0000);
      check("w_carry", 32'(carry_w), 32'd1);
      check("w_zero", 32'(zero_w), 32'd1);
      repeat (2) @(posedge clk);
      #1 check("w_halted", 32'(halted_w), 32'd1);
      $display("prog wide: acc=%h carry=%b zero=%b halted=%b", acc_w, carry_w, zero_w, halted_w);

      // PM_DEPTH=4: address wrap, then asynchronous reset in the middle of EXEC
      prog_p[0] = 12'h1FF; prog_p[1] = 12'h300; prog_p[2] = 12'h400; prog_p[3] = 12'h000;
      @(negedge clk);
      nreset_p = 1'b1; run_p = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("p_addr_seq", 32'(pm_addr_p), 32'(exp_seq[k]));
         if (k < 4) repeat (2) @(negedge clk);
      end
      @(posedge clk);
      #2;
      check("p_pre_acc", 32'(acc_p), 32'hFE);
      check("p_pre_carry", 32'(carry_p), 32'd1);
      nreset_p = 1'b0;
      #1;
      check("p_rst_acc", 32'(acc_p), 32'd0);
      check("p_rst_pm_addr", 32'(pm_addr_p), 32'd0);
      check("p_rst_carry", 32'(carry_p), 32'd0);
      check("p_rst_zero", 32'(zero_p), 32'd0);
      check("p_rst_halted", 32'(halted_p), 32'd0);
      $display("prog wrap: acc=%h pm_addr=%0d carry=%b zero=%b", acc_p, pm_addr_p, carry_p, zero_p);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
